mem_port_arbiter: RTL and testbench

Two-port arbiter that shares the single off-chip Data_Memory port between the data-cache controller (port 0) and the instruction-cache refill path (port 1). It sits between the cache controllers and Data_Memory, replacing the direct mem_* wiring from the cache to memory. It serialises whole-line read/write transactions, grants requesters round-robin, returns read data, and flags memory that never acknowledges.

---
 rtl/mem_port_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares the single off-chip Data_Memory port between the data-cache
// controller (port 0) and the instruction-cache refill path (port 1).
// Whole-line read/write transactions are serialised one at a time. Ports are
// granted round-robin, read data is returned to the requester, and memory
// that never acknowledges is flagged.
//
// Ports
//   clk_i, rst_i          clock (rising edge) / synchronous active-low reset
//   req_i[1:0]            per-port request, held with stable fields until ack_o
//   write_i[1:0]          per-port direction: 1 = line write, 0 = line read
//   addr0_i, addr1_i      per-port line address
//   wdata0_i, wdata1_i    per-port line write data
//   ack_o[1:0]            per-port one-cycle completion pulse
//   rdata_o               read data, valid while ack_o pulses for a read
//   err_o                 sticky timeout flag, cleared only by reset
//   busy_o                high whenever a transaction is in progress
//   mem_enable_o          memory request, held for the whole transaction
//   mem_write_o           memory write strobe
//   mem_addr_o            memory address
//   mem_data_o            memory write data
//   mem_data_i            memory read data, valid with mem_ack_i
//   mem_ack_i             memory completion pulse
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int LINE_W  = 256,
    parameter int TIMEOUT = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [1:0]        req_i,
    input  logic [1:0]        write_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [LINE_W-1:0] wdata0_i,
    input  logic [LINE_W-1:0] wdata1_i,
    output logic [1:0]        ack_o,
    output logic [LINE_W-1:0] rdata_o,
    output logic              err_o,
    output logic              busy_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic              grant_reg, grant_next;
    logic              last_served_reg, last_served_next;
    logic [1:0]        mask_reg, mask_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [1:0]        ack_reg, ack_next;
    logic [LINE_W-1:0] rdata_reg, rdata_next;
    logic              err_reg, err_next;
    logic              busy_reg, busy_next;
    logic              mem_enable_reg, mem_enable_next;
    logic              mem_write_reg, mem_write_next;
    logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
    logic [LINE_W-1:0] mem_data_reg, mem_data_next;

    // Per-port request fields gathered into arrays so the granted port can
    // be selected by index.
    logic [ADDR_W-1:0] port_addr  [2];
    logic [LINE_W-1:0] port_wdata [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            if (gi == 0) begin : g_p0
                assign port_addr[gi]  = addr0_i;
                assign port_wdata[gi] = wdata0_i;
            end else begin : g_p1
                assign port_addr[gi]  = addr1_i;
                assign port_wdata[gi] = wdata1_i;
            end
        end
    endgenerate

    // Round-robin pick. The mask keeps the port just served from being
    // re-granted on its stale request in the IDLE cycle right after ack_o.
    logic [1:0] eligible;
    logic       pick;

    always_comb begin
        eligible = req_i & ~mask_reg;
        if (eligible == 2'b11) begin
            pick = ~last_served_reg;
        end else begin
            pick = ~eligible[0];
        end
    end

    always_comb begin
        state_next       = state_reg;
        grant_next       = grant_reg;
        last_served_next = last_served_reg;
        mask_next        = 2'b00;
        cnt_next         = cnt_reg;
        ack_next         = 2'b00;
        rdata_next       = rdata_reg;
        err_next         = err_reg;
        mem_enable_next  = mem_enable_reg;
        mem_write_next   = mem_write_reg;
        mem_addr_next    = mem_addr_reg;
        mem_data_next    = mem_data_reg;

        case (state_reg)
            IDLE: begin
                if (eligible != 2'b00) begin
                    grant_next      = pick;
                    mem_addr_next   = port_addr[pick];
                    mem_data_next   = port_wdata[pick];
                    mem_write_next  = write_i[pick];
                    mem_enable_next = 1'b1;
                    cnt_next        = '0;
                    state_next      = BUSY;
                end
            end
            BUSY: begin
                cnt_next = cnt_reg + 1'b1;
                // An ack in the final counted cycle still completes normally.
                if (mem_ack_i) begin
                    if (!mem_write_reg) begin
                        rdata_next = mem_data_i;
                    end
                    mem_enable_next = 1'b0;
                    mem_write_next  = 1'b0;
                    ack_next        = grant_reg ? 2'b10 : 2'b01;
                    state_next      = RESP;
                end else if (cnt_reg == CNT_LAST) begin
                    err_next        = 1'b1;
                    rdata_next      = '0;
                    mem_enable_next = 1'b0;
                    mem_write_next  = 1'b0;
                    ack_next        = grant_reg ? 2'b10 : 2'b01;
                    state_next      = RESP;
                end
            end
            RESP: begin
                last_served_next = grant_reg;
                mask_next        = grant_reg ? 2'b10 : 2'b01;
                state_next       = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_reg       <= IDLE;
            grant_reg       <= 1'b0;
            last_served_reg <= 1'b1;   // port 0 wins the first tie
            mask_reg        <= 2'b00;
            cnt_reg         <= '0;
            ack_reg         <= 2'b00;
            rdata_reg       <= '0;
            err_reg         <= 1'b0;
            busy_reg        <= 1'b0;
            mem_enable_reg  <= 1'b0;
            mem_write_reg   <= 1'b0;
            mem_addr_reg    <= '0;
            mem_data_reg    <= '0;
        end else begin
            state_reg       <= state_next;
            grant_reg       <= grant_next;
            last_served_reg <= last_served_next;
            mask_reg        <= mask_next;
            cnt_reg         <= cnt_next;
            ack_reg         <= ack_next;
            rdata_reg       <= rdata_next;
            err_reg         <= err_next;
            busy_reg        <= busy_next;
            mem_enable_reg  <= mem_enable_next;
            mem_write_reg   <= mem_write_next;
            mem_addr_reg    <= mem_addr_next;
            mem_data_reg    <= mem_data_next;
        end
    end

    assign ack_o        = ack_reg;
    assign rdata_o      = rdata_reg;
    assign err_o        = err_reg;
    assign busy_o       = busy_reg;
    assign mem_enable_o = mem_enable_reg;
    assign mem_write_o  = mem_write_reg;
    assign mem_addr_o   = mem_addr_reg;
    assign mem_data_o   = mem_data_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Randomised bench for mem_port_arbiter. Two requester agents issue random
// line reads/writes, a memory responder answers with random latency (or
// never, to force timeouts), and a transaction-level timeline model predicts
// grant order, enable window, ack cycle, read data and the sticky error flag.
// Two resets are injected mid-transaction; the interrupted request is simply
// kept pending by its requester and must complete after reset.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int ADDR_W  = 32;
    localparam int LINE_W  = 256;
    localparam int TIMEOUT = 64;
    localparam int N_TXN   = 40;
    localparam int LIMIT   = 20000;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [1:0]        req_i;
    logic [1:0]        write_i;
    logic [ADDR_W-1:0] addr0_i, addr1_i;
    logic [LINE_W-1:0] wdata0_i, wdata1_i;
    logic [1:0]        ack_o;
    logic [LINE_W-1:0] rdata_o;
    logic              err_o;
    logic              busy_o;
    logic              mem_enable_o;
    logic              mem_write_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [LINE_W-1:0] mem_data_o;
    logic [LINE_W-1:0] mem_data_i;
    logic              mem_ack_i;

    mem_port_arbiter #(
        .ADDR_W (ADDR_W),
        .LINE_W (LINE_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_i       (req_i),
        .write_i     (write_i),
        .addr0_i     (addr0_i),
        .addr1_i     (addr1_i),
        .wdata0_i    (wdata0_i),
        .wdata1_i    (wdata1_i),
        .ack_o       (ack_o),
        .rdata_o     (rdata_o),
        .err_o       (err_o),
        .busy_o      (busy_o),
        .mem_enable_o(mem_enable_o),
        .mem_write_o (mem_write_o),
        .mem_addr_o  (mem_addr_o),
        .mem_data_o  (mem_data_o),
        .mem_data_i  (mem_data_i),
        .mem_ack_i   (mem_ack_i)
    );

    always #5 clk_i = ~clk_i;

    int checks_total  = 0;
    int checks_passed = 0;
    int c = 0;

    task automatic check_val(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks_total++;
        if (got === exp) begin
            checks_passed++;
        end else begin
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, c, got, exp);
        end
    endtask

    // Behavioural memory contents; untouched lines read back a pattern of
    // their own address.
    logic [LINE_W-1:0] mm [int unsigned];

    function automatic logic [LINE_W-1:0] mem_read(input logic [ADDR_W-1:0] a);
        if (mm.exists(a)) return mm[a];
        return {8{a}};
    endfunction

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Timeline model of the transaction in flight.
    bit                m_busy = 0;
    int                m_port, m_start, m_len;
    bit                m_timeout, m_write;
    logic [ADDR_W-1:0] m_addr;
    logic [LINE_W-1:0] m_data;
    int                m_free = 0;
    logic [1:0]        m_mask = 2'b00;
    int                m_last = 1;
    logic              m_err = 1'b0;
    logic [LINE_W-1:0] m_rdata = '0;

    // Requester agents.
    bit                r_active [2];
    int                r_tail   [2];
    int                r_gap    [2];
    int                n_left   [2];
    logic [ADDR_W-1:0] r_addr   [2];
    logic [LINE_W-1:0] r_wdata  [2];
    bit                r_write  [2];

    initial begin
        logic [1:0] req_v;
        logic [1:0] elig;
        logic [1:0] exp_ack;
        bit         exp_en, exp_ackc, exp_bsy, in_win, do_rst, rst_chk;
        int         n_rst, late_ack_cyc, k;

        rst_i = 1'b0; req_i = 2'b00; write_i = 2'b00;
        addr0_i = '0; addr1_i = '0; wdata0_i = '0; wdata1_i = '0;
        mem_data_i = '0; mem_ack_i = 1'b0;
        for (int p = 0; p < 2; p++) begin
            r_active[p] = 0; r_tail[p] = 0; r_gap[p] = 0; n_left[p] = N_TXN;
            r_addr[p] = '0; r_wdata[p] = '0; r_write[p] = 0;
        end
        n_rst = 0; rst_chk = 0; late_ack_cyc = -1;

        repeat (3) @(posedge clk_i);
        #1;
        check_val("rst_mem", 512'({mem_addr_o, mem_data_o}), 512'(0));
        check_val("rst_rdata", 512'(rdata_o), 512'(0));

        while ((n_left[0] > 0 || n_left[1] > 0 || r_active[0] || r_active[1] || m_busy) && c < LIMIT) begin
            // ---- expected outputs for this cycle ----
            exp_en   = m_busy && c >= m_start && c < m_start + m_len;
            exp_ackc = m_busy && c == m_start + m_len;
            exp_bsy  = m_busy && c >= m_start && c <= m_start + m_len;
            exp_ack  = exp_ackc ? (m_port == 1 ? 2'b10 : 2'b01) : 2'b00;
            if (exp_ackc) begin
                if (m_timeout) begin
                    m_err   = 1'b1;
                    m_rdata = '0;
                end else if (!m_write) begin
                    m_rdata = mem_read(m_addr);
                end
            end
            check_val("status", 512'({ack_o, busy_o, mem_enable_o, mem_write_o, err_o}),
                      512'({exp_ack, exp_bsy, exp_en, exp_en && m_write, m_err}));
            if (exp_en)
                check_val("mem_fields", 512'({mem_addr_o, mem_data_o}), 512'({m_addr, m_data}));
            if (exp_ackc)
                check_val("rdata", 512'(rdata_o), 512'(m_rdata));
            if (rst_chk) begin
                check_val("rst_mem", 512'({mem_addr_o, mem_data_o}), 512'(0));
                check_val("rst_rdata", 512'(rdata_o), 512'(0));
                rst_chk = 0;
            end
            if (exp_ackc) begin
                m_last = m_port;
                if (m_write && !m_timeout) mm[m_addr] = m_data;
                m_busy = 0;
                m_free = c + 1;
                m_mask = (m_port == 1) ? 2'b10 : 2'b01;
            end

            // ---- requester agents ----
            for (int p = 0; p < 2; p++) begin
                if (ack_o[p] && r_active[p]) begin
                    r_active[p] = 0;
                    r_tail[p]   = 1 + $urandom_range(0, 1);
                    r_gap[p]    = $urandom_range(0, 3);
                end
                if (r_active[p]) begin
                    req_v[p] = 1'b1;
                end else if (r_tail[p] > 0) begin
                    req_v[p] = 1'b1;
                    r_tail[p]--;
                end else if (r_gap[p] > 0) begin
                    req_v[p] = 1'b0;
                    r_gap[p]--;
                end else if (n_left[p] > 0) begin
                    r_active[p] = 1;
                    r_addr[p]   = 32'($urandom_range(0, 15)) << 5;
                    r_write[p]  = ($urandom_range(0, 4) < 2);
                    r_wdata[p]  = rand_line();
                    n_left[p]--;
                    req_v[p]    = 1'b1;
                end else begin
                    req_v[p] = 1'b0;
                end
            end
            req_i    = req_v;
            write_i  = {r_write[1], r_write[0]};
            addr0_i  = r_addr[0];
            addr1_i  = r_addr[1];
            wdata0_i = r_wdata[0];
            wdata1_i = r_wdata[1];

            // ---- reset injection / grant prediction ----
            do_rst = (n_rst < 2) && (c > 300 * (n_rst + 1)) && m_busy &&
                     c >= m_start && c < m_start + m_len - 1;
            rst_i = !do_rst;
            if (do_rst) begin
                m_busy = 0; m_err = 1'b0; m_rdata = '0; m_last = 1;
                m_free = c + 1; m_mask = 2'b00;
                rst_chk = 1; late_ack_cyc = c + 1; n_rst++;
            end else if (!m_busy && c >= m_free) begin
                elig = req_v & ((c == m_free) ? ~m_mask : 2'b11);
                if (elig != 2'b00) begin
                    m_port    = (elig == 2'b11) ? (1 - m_last) : (elig[0] ? 0 : 1);
                    m_addr    = r_addr[m_port];
                    m_data    = r_wdata[m_port];
                    m_write   = r_write[m_port];
                    m_busy    = 1;
                    m_start   = c + 1;
                    k = $urandom_range(0, 9);
                    if (k == 0) begin
                        m_timeout = 1; m_len = TIMEOUT;
                    end else begin
                        m_timeout = 0;
                        m_len = (k == 1) ? $urandom_range(TIMEOUT - 4, TIMEOUT) : $urandom_range(1, 8);
                    end
                end
            end

            // ---- memory responder ----
            in_win = m_busy && c >= m_start && c < m_start + m_len;
            mem_data_i = rand_line();
            if (in_win) begin
                mem_ack_i = (!m_timeout && c == m_start + m_len - 1);
                if (mem_ack_i && !m_write) mem_data_i = mem_read(m_addr);
            end else begin
                mem_ack_i = (c == late_ack_cyc) || ($urandom_range(0, 19) == 0);
            end

            @(posedge clk_i);
            #1;
            c++;
        end

        check_val("cycle_budget", 512'(c < LIMIT), 512'(1));
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
